// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares the single memory block between up to four clients,
// sequencing one read or cons-cell allocation at a time and returning a one-cycle done pulse.
module mem_arbiter #(
    parameter int          NumClients    = 2,
    parameter int          TimeoutCycles = 255,
    parameter logic [15:0] NilValue      = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NumClients-1:0]      cl_req,
    input  logic [NumClients-1:0]      cl_alloc,
    input  logic [NumClients-1:0][15:0] cl_addr,
    input  logic [NumClients-1:0][14:0] cl_type,
    input  logic [NumClients-1:0][15:0] cl_car,
    input  logic [NumClients-1:0][15:0] cl_cdr,
    output logic [NumClients-1:0]      cl_done,
    output logic [15:0]                cl_rdata,
    output logic                       cl_err,
    output logic                       busy,
    output logic [1:0]                 grant_id,
    output logic                       mem_req,
    output logic [15:0]                mem_addr,
    input  logic                       mem_data_ready,
    input  logic [15:0]                mem_data_out,
    output logic                       mem_write_enable,
    output logic [14:0]                mem_data_type,
    output logic [15:0]                mem_car,
    output logic [15:0]                mem_cdr,
    input  logic                       mem_write_done,
    input  logic [15:0]                mem_ptr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_next;
    logic [1:0]  rr_ptr;
    logic [7:0]  tcount;
    logic [15:0] lat_addr, lat_car, lat_cdr;
    logic [14:0] lat_type;

    logic [3:0]  req_pad;
    logic [2:0]  cand;
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  rr_next;
    logic        sel_alloc;
    logic [15:0] sel_addr, sel_car, sel_cdr;
    logic [14:0] sel_type;
    logic        timeout_hit;

    // Cyclic search starting at rr_ptr; requests are padded to four so indices stay 2 bits wide.
    always_comb begin
        req_pad = '0;
        req_pad[NumClients-1:0] = cl_req;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NumClients; i++) begin
            cand = {1'b0, rr_ptr} + 3'(i);
            if (cand >= 3'(NumClients)) cand = cand - 3'(NumClients);
            if (!grant_found && req_pad[cand[1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
    end

    assign rr_next = (grant_idx == 2'(NumClients - 1)) ? 2'd0 : grant_idx + 2'd1;

    always_comb begin
        sel_alloc = 1'b0;
        sel_addr  = '0;
        sel_type  = '0;
        sel_car   = '0;
        sel_cdr   = '0;
        for (int i = 0; i < NumClients; i++) begin
            if (grant_idx == 2'(i)) begin
                sel_alloc = cl_alloc[i];
                sel_addr  = cl_addr[i];
                sel_type  = cl_type[i];
                sel_car   = cl_car[i];
                sel_cdr   = cl_cdr[i];
            end
        end
    end

    // Fires in the last permitted wait cycle, so a stalled client spends TimeoutCycles cycles waiting.
    assign timeout_hit = (tcount >= 8'(TimeoutCycles - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = sel_alloc ? WRITE : READ;
            READ:    if (mem_data_ready || timeout_hit) state_next = RESP;
            WRITE:   if (mem_write_done || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            tcount   <= '0;
            grant_id <= '0;
            cl_rdata <= '0;
            cl_err   <= 1'b0;
            lat_addr <= '0;
            lat_type <= '0;
            lat_car  <= '0;
            lat_cdr  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        grant_id <= grant_idx;
                        rr_ptr   <= rr_next;
                        lat_addr <= sel_addr;
                        lat_type <= sel_type;
                        lat_car  <= sel_car;
                        lat_cdr  <= sel_cdr;
                        tcount   <= '0;
                        cl_err   <= 1'b0;
                    end
                end
                READ: begin
                    if (mem_data_ready) begin
                        cl_rdata <= mem_data_out;
                    end else if (timeout_hit) begin
                        cl_rdata <= NilValue;
                        cl_err   <= 1'b1;
                    end
                    if (tcount != 8'hFF) tcount <= tcount + 8'd1;
                end
                WRITE: begin
                    if (mem_write_done) begin
                        cl_rdata <= mem_ptr;
                    end else if (timeout_hit) begin
                        cl_rdata <= NilValue;
                        cl_err   <= 1'b1;
                    end
                    if (tcount != 8'hFF) tcount <= tcount + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cl_done = '0;
        for (int i = 0; i < NumClients; i++) begin
            cl_done[i] = (state == RESP) && (grant_id == 2'(i));
        end
    end

    assign busy             = (state != IDLE);
    assign mem_req          = (state == READ);
    assign mem_addr         = lat_addr;
    // The wait counter is zero only in the first WRITE cycle, giving a single-cycle strobe.
    assign mem_write_enable = (state == WRITE) && (tcount == 8'd0);
    assign mem_data_type    = lat_type;
    assign mem_car          = lat_car;
    assign mem_cdr          = lat_cdr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written arbitration, fairness, timeout and reset sequences.
module tb_mem_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]       cl_req, cl_alloc, cl_done;
    logic [N-1:0][15:0] cl_addr, cl_car, cl_cdr;
    logic [N-1:0][14:0] cl_type;
    logic [15:0]        cl_rdata, mem_addr, mem_data_out, mem_car, mem_cdr, mem_ptr;
    logic [14:0]        mem_data_type;
    logic [1:0]         grant_id;
    logic               cl_err, busy, mem_req, mem_data_ready, mem_write_enable, mem_write_done;

    mem_arbiter #(.NumClients(N), .TimeoutCycles(255)) dut (
        .clk(clk), .rst(rst),
        .cl_req(cl_req), .cl_alloc(cl_alloc), .cl_addr(cl_addr), .cl_type(cl_type),
        .cl_car(cl_car), .cl_cdr(cl_cdr), .cl_done(cl_done), .cl_rdata(cl_rdata),
        .cl_err(cl_err), .busy(busy), .grant_id(grant_id),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data_ready(mem_data_ready),
        .mem_data_out(mem_data_out), .mem_write_enable(mem_write_enable),
        .mem_data_type(mem_data_type), .mem_car(mem_car), .mem_cdr(mem_cdr),
        .mem_write_done(mem_write_done), .mem_ptr(mem_ptr)
    );

    // Memory stub: 1-cycle read pulse, 1-cycle allocation; cell laid out as type, car, cdr with ptr at cdr.
    logic [15:0] mem [0:255];
    logic [7:0]  free_ptr;
    logic        stall_write;
    always @(posedge clk) begin
        if (rst) begin
            mem_data_ready <= 1'b0;
            mem_write_done <= 1'b0;
            mem_ptr        <= 16'h0;
            free_ptr       <= 8'h40;
            mem[8'h05]     <= 16'hDEAD;
            mem[8'h10]     <= 16'h1234;
            mem[8'hFF]     <= 16'h8001;
        end else begin
            mem_data_ready <= mem_req && !mem_data_ready;
            mem_write_done <= mem_write_enable && !stall_write;
            if (mem_write_enable && !stall_write) begin
                mem[free_ptr]        <= {1'b0, mem_data_type};
                mem[free_ptr + 8'd1] <= mem_car;
                mem[free_ptr + 8'd2] <= mem_cdr;
                mem_ptr              <= {8'h00, free_ptr + 8'd2};
                free_ptr             <= free_ptr + 8'd3;
            end
        end
        mem_data_out <= mem[mem_addr[7:0]];
    end

    int req_total = 0, we_total = 0, done_total = 0;
    always @(negedge clk) begin
        if (mem_req)          req_total  <= req_total + 1;
        if (mem_write_enable) we_total   <= we_total + 1;
        if (cl_done != '0)    done_total <= done_total + 1;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic run_txn(input int c, input logic alloc, input logic [15:0] addr,
                           input logic [14:0] typ, input logic [15:0] car, input logic [15:0] cdr,
                           input logic [15:0] exp_rd, input logic exp_err, input int exp_lat,
                           input string nm);
        int cyc, r0, w0;
        logic seen;
        tick;
        r0 = req_total;
        w0 = we_total;
        cl_req[c] = 1'b1; cl_alloc[c] = alloc; cl_addr[c] = addr;
        cl_type[c] = typ; cl_car[c] = car; cl_cdr[c] = cdr;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            tick;
            cyc++;
            if (cl_done != '0) seen = 1'b1;
        end
        chk({nm, "_done"}, 32'(cl_done), 32'(1 << c));
        chk({nm, "_rdata"}, 32'(cl_rdata), 32'(exp_rd));
        chk({nm, "_err"}, 32'(cl_err), 32'(exp_err));
        chk({nm, "_grant"}, 32'(grant_id), 32'(c));
        chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, "_req_cycles"}, 32'(req_total - r0), alloc ? 32'd0 : 32'd2);
        chk({nm, "_we_cycles"}, 32'(we_total - w0), alloc ? 32'd1 : 32'd0);
        cl_req[c] = 1'b0;
    endtask

    // Both clients request reads together; records done order, gaps and data.
    task automatic both_req(input int ntx, input logic drop, output int order[6],
                            output int gap[6], output logic [15:0] rd[6]);
        int cyc, got, last;
        for (int k = 0; k < 6; k++) begin
            order[k] = -1; gap[k] = -1; rd[k] = 16'hxxxx;
        end
        tick;
        cl_alloc = '0;
        cl_addr[0] = 16'h0005;
        cl_addr[1] = 16'h0010;
        cl_req = 2'b11;
        cyc = 0; got = 0; last = 0;
        while (got < ntx && cyc < 200) begin
            tick;
            cyc++;
            if (cl_done != '0) begin
                order[got] = (cl_done == 2'b10) ? 1 : (cl_done == 2'b01) ? 0 : 9;
                gap[got]   = cyc - last;
                rd[got]    = cl_rdata;
                last       = cyc;
                if (drop && order[got] < 2) cl_req[order[got]] = 1'b0;
                got++;
            end
        end
        cl_req = '0;
    endtask

    typedef struct {
        int          c;
        logic        alloc;
        logic [15:0] addr;
        logic [14:0] typ;
        logic [15:0] car;
        logic [15:0] cdr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[9];
    int order[6], gap[6];
    logic [15:0] rd[6];
    int d0;

    initial begin
        vecs[0] = '{0, 1'b0, 16'h0005, 15'h0, 16'h0, 16'h0, 16'hDEAD};
        vecs[1] = '{1, 1'b1, 16'h0000, 15'h2, 16'hBEEF, 16'h0000, 16'h0042};
        vecs[2] = '{0, 1'b0, 16'h0041, 15'h0, 16'h0, 16'h0, 16'hBEEF};
        vecs[3] = '{1, 1'b0, 16'h0010, 15'h0, 16'h0, 16'h0, 16'h1234};
        vecs[4] = '{0, 1'b1, 16'h0000, 15'h3, 16'h0042, 16'h0007, 16'h0045};
        vecs[5] = '{1, 1'b0, 16'h0044, 15'h0, 16'h0, 16'h0, 16'h0042};
        vecs[6] = '{0, 1'b0, 16'h0045, 15'h0, 16'h0, 16'h0, 16'h0007};
        vecs[7] = '{1, 1'b0, 16'h0043, 15'h0, 16'h0, 16'h0, 16'h0003};
        vecs[8] = '{0, 1'b0, 16'hFFFF, 15'h0, 16'h0, 16'h0, 16'h8001};

        cl_req = '0; cl_alloc = '0; cl_addr = '0; cl_type = '0; cl_car = '0; cl_cdr = '0;
        stall_write = 1'b0;
        rst = 1'b1;
        repeat (3) tick;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(cl_done), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_we", 32'(mem_write_enable), 32'd0);
        chk("reset_grant", 32'(grant_id), 32'd0);
        chk("reset_rdata", 32'(cl_rdata), 32'd0);
        chk("reset_err", 32'(cl_err), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_car", 32'({mem_car, mem_cdr}), 32'd0);
        chk("reset_mem_type", 32'(mem_data_type), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].c, vecs[i].alloc, vecs[i].addr, vecs[i].typ, vecs[i].car,
                    vecs[i].cdr, vecs[i].exp_rd, 1'b0, 3, $sformatf("vec%0d", i));
        end

        // Simultaneous requests straight after reset.
        tick; rst = 1'b1; tick; rst = 1'b0;
        both_req(2, 1'b1, order, gap, rd);
        chk("simul_first", 32'(order[0]), 32'd0);
        chk("simul_second", 32'(order[1]), 32'd1);
        chk("simul_gap_ge4", 32'(gap[1] >= 4), 32'd1);
        chk("simul_rd1", 32'(rd[1]), 32'h1234);

        // Fairness with both requests held continuously.
        both_req(6, 1'b0, order, gap, rd);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fair_order%0d", k), 32'(order[k]), 32'(k % 2));
            chk($sformatf("fair_rd%0d", k), 32'(rd[k]), (k % 2) ? 32'h1234 : 32'hDEAD);
            if (k > 0) chk($sformatf("fair_gap%0d", k), 32'(gap[k]), 32'd4);
        end

        // Allocation that never completes, then a normal read.
        stall_write = 1'b1;
        run_txn(0, 1'b1, 16'h0, 15'h2, 16'h0001, 16'h0002, 16'h0000, 1'b1, 256, "timeout");
        stall_write = 1'b0;
        tick;
        chk("timeout_idle", 32'(busy), 32'd0);
        run_txn(1, 1'b0, 16'h0005, 15'h0, 16'h0, 16'h0, 16'hDEAD, 1'b0, 3, "after_timeout");

        // Reset while client 0 is in READ; rr_ptr would otherwise point at client 1.
        run_txn(1, 1'b0, 16'h0010, 15'h0, 16'h0, 16'h0, 16'h1234, 1'b0, 3, "pre_reset");
        tick;
        cl_alloc[0] = 1'b0; cl_addr[0] = 16'h0005; cl_req[0] = 1'b1;
        tick;
        chk("midread_req", 32'(mem_req), 32'd1);
        chk("midread_busy", 32'(busy), 32'd1);
        d0 = done_total;
        rst = 1'b1;
        tick;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(cl_done), 32'd0);
        rst = 1'b0;
        cl_req = '0;
        repeat (3) tick;
        chk("rst_no_done", 32'(done_total - d0), 32'd0);
        both_req(2, 1'b1, order, gap, rd);
        chk("rst_next_grant", 32'(order[0]), 32'd0);
        chk("rst_next_rd", 32'(rd[0]), 32'hDEAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
